// File: rtl/imem_prefetch.sv
// imem_prefetch: registered-read instruction memory with a prefetch response FIFO.
//
// Fetch requests (byte addresses) are accepted with a valid/ready handshake.
// Each accepted request is checked for faults and read from the word array
// into stage S1. One edge later it moves into the response FIFO, and the
// consumer drains the FIFO with its own valid/ready handshake. A run-time
// load port writes the array. Flush discards everything in flight.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   ReqValid/ReqReady   request handshake; ReqAddress is the byte address
//   RespValid/RespReady response handshake; RespInstruction/RespFault hold the FIFO head
//   LoadEn/LoadAddress/LoadData  word write into the array
//   Flush               drop all in-flight and buffered responses
module imem_prefetch #(
  parameter int unsigned ADDR_BITS      = 9,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned PREFETCH_DEPTH = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [31:0]          ReqAddress,
  output logic                 RespValid,
  input  logic                 RespReady,
  output logic [WIDTH-1:0]     RespInstruction,
  output logic                 RespFault,
  input  logic                 LoadEn,
  input  logic [ADDR_BITS-1:0] LoadAddress,
  input  logic [WIDTH-1:0]     LoadData,
  input  logic                 Flush
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned PTR_W = $clog2(PREFETCH_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Word array; contents survive Reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Stage S1: registered read result.
  logic             s1_valid_q, s1_valid_d;
  logic             s1_fault_q, s1_fault_d;
  logic [WIDTH-1:0] s1_data_q;

  // Response FIFO.
  logic [WIDTH-1:0]          fifo_data_q [PREFETCH_DEPTH];
  logic [PREFETCH_DEPTH-1:0] fifo_fault_q;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                 req_fire_c;
  logic                 req_fault_c;
  logic [ADDR_BITS-1:0] req_idx_c;
  logic                 push_c;
  logic                 pop_c;
  logic [CNT_W-1:0]     occ_c;

  // Address decode: word index plus misalignment / out-of-range fault.
  always_comb begin
    req_idx_c   = ReqAddress[ADDR_BITS+1:2];
    req_fault_c = (ReqAddress[1:0] != 2'b00) || (ReqAddress[31:ADDR_BITS+2] != '0);
  end

  // Handshakes. Occupancy counts the S1 entry so that a full FIFO plus S1
  // can never overflow, while still allowing one accept per cycle when the
  // consumer pops every cycle.
  always_comb begin
    RespValid  = (count_q != '0);
    pop_c      = RespValid && RespReady;
    push_c     = s1_valid_q;
    occ_c      = count_q + CNT_W'(s1_valid_q) - CNT_W'(pop_c);
    ReqReady   = !Reset && !LoadEn && !Flush && (occ_c < CNT_W'(PREFETCH_DEPTH));
    req_fire_c = ReqValid && ReqReady;
  end

  // Head of FIFO drives the response; zeros when empty.
  always_comb begin
    RespInstruction = '0;
    RespFault       = 1'b0;
    if (RespValid) begin
      RespInstruction = fifo_data_q[rd_ptr_q];
      RespFault       = fifo_fault_q[rd_ptr_q];
    end
  end

  // Array write and registered read. ReqReady is low whenever LoadEn is high,
  // so a read and a write never happen in the same cycle.
  always_ff @(posedge Clk) begin
    if (LoadEn) begin
      mem_q[LoadAddress] <= LoadData;
    end
    if (req_fire_c) begin
      s1_data_q <= req_fault_c ? '0 : mem_q[req_idx_c];
    end
  end

  // FIFO storage; a push during Flush writes a slot that the pointer reset abandons.
  always_ff @(posedge Clk) begin
    if (push_c) begin
      fifo_data_q[wr_ptr_q]  <= s1_data_q;
      fifo_fault_q[wr_ptr_q] <= s1_fault_q;
    end
  end

  // Next-state for S1 control, pointers and count.
  always_comb begin
    s1_valid_d = req_fire_c;
    s1_fault_d = s1_fault_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (req_fire_c) begin
      s1_fault_d = req_fault_c;
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (Flush) begin
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_fault_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fault_q <= s1_fault_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_imem_prefetch.sv
// Self-checking bench for imem_prefetch (default parameters).
// Inputs change 1 time unit after the rising edge. The monitor samples on the
// falling edge, where the values it sees are the ones the next rising edge
// will act on.
module tb_imem_prefetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddress;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespInstruction;
  logic        RespFault;
  logic        LoadEn;
  logic [8:0]  LoadAddress;
  logic [31:0] LoadData;
  logic        Flush;

  int vectors = 0;
  int errors  = 0;
  int pop_cnt = 0;
  int fault_cnt = 0;
  logic [31:0] last_data = '0;
  logic [32:0] sb [$];
  logic [31:0] model_mem [512];

  imem_prefetch dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddress(ReqAddress),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespInstruction(RespInstruction), .RespFault(RespFault),
    .LoadEn(LoadEn), .LoadAddress(LoadAddress), .LoadData(LoadData),
    .Flush(Flush)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] expect_resp(input logic [31:0] a);
    logic flt;
    flt = (a[1:0] != 2'b00) || (a[31:11] != 21'd0);
    return flt ? {1'b1, 32'h0} : {1'b0, model_mem[a[10:2]]};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || RespValid) && n < 50) begin
      tick();
      n++;
    end
    check("drain_done", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: push on accept, pop/compare on response handshake.
  always @(negedge Clk) begin
    if (Reset) begin
      sb.delete();
    end else begin
      if (RespValid && RespReady) begin
        pop_cnt++;
        last_data = RespInstruction;
        if (RespFault) fault_cnt++;
        if (sb.size() == 0) check("unexpected_resp", 64'(RespValid), 64'd0);
        else check("resp", 64'({RespFault, RespInstruction}), 64'(sb.pop_front()));
      end
      if (ReqValid && ReqReady) sb.push_back(expect_resp(ReqAddress));
      if (Flush) sb.delete();
    end
    if (LoadEn) model_mem[LoadAddress] = LoadData;
  end

  initial begin
    int accepts;
    int base;
    logic rdy;
    logic [31:0] addr;
    for (int i = 0; i < 512; i++) model_mem[i] = '0;
    Reset = 1'b1; ReqValid = 1'b1; ReqAddress = '0; RespReady = 1'b0;
    LoadEn = 1'b0; LoadAddress = '0; LoadData = '0; Flush = 1'b0;

    // Reset held with a pending request.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_req_ready", 64'(ReqReady), 64'd0);
      check("rst_resp_valid", 64'(RespValid), 64'd0);
      check("rst_instr", 64'(RespInstruction), 64'd0);
      check("rst_fault", 64'(RespFault), 64'd0);
    end
    Reset = 1'b0; ReqValid = 1'b0;
    tick();
    check("post_rst_ready", 64'(ReqReady), 64'd1);

    // Load mem[0..7].
    for (int i = 0; i < 8; i++) begin
      LoadEn = 1'b1; LoadAddress = 9'(i); LoadData = 32'h1000_0000 + 32'(i);
      tick();
    end
    LoadEn = 1'b0;

    // Back-to-back stream, consumer always ready.
    base = pop_cnt;
    RespReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ReqValid = 1'b1; ReqAddress = 32'(4 * i);
      #0 check("stream_ready", 64'(ReqReady), 64'd1);
      tick();
      if (i == 0) check("latency_edge1", 64'(RespValid), 64'd0);
      else check("stream_valid", 64'(RespValid), 64'd1);
    end
    ReqValid = 1'b0;
    drain();
    check("stream_count", 64'(pop_cnt - base), 64'd8);
    check("stream_last", 64'(last_data), 64'h1000_0007);

    // Backpressure: only PREFETCH_DEPTH accepts while the consumer stalls.
    base = pop_cnt;
    RespReady = 1'b0; ReqValid = 1'b1; addr = '0; accepts = 0;
    for (int i = 0; i < 6; i++) begin
      ReqAddress = addr;
      #0 rdy = ReqReady;
      tick();
      if (rdy) begin accepts++; addr = (addr + 32'd4) & 32'h1C; end
    end
    check("bp_accepts", 64'(accepts), 64'd2);
    check("bp_ready_low", 64'(ReqReady), 64'd0);
    RespReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ReqAddress = addr;
      #0 rdy = ReqReady;
      tick();
      if (rdy) begin accepts++; addr = (addr + 32'd4) & 32'h1C; end
    end
    ReqValid = 1'b0;
    drain();
    check("bp_no_loss", 64'(pop_cnt - base), 64'(accepts));

    // Faults plus the last in-range word.
    LoadEn = 1'b1; LoadAddress = 9'd511; LoadData = 32'hDEAD_BEEF;
    tick();
    LoadEn = 1'b0;
    base = fault_cnt;
    ReqValid = 1'b1; ReqAddress = 32'h0000_0002; tick();
    ReqAddress = 32'h0000_0800; tick();
    ReqAddress = 32'h0000_07FC; tick();
    ReqValid = 1'b0;
    drain();
    check("fault_count", 64'(fault_cnt - base), 64'd2);
    check("last_word", 64'(last_data), 64'hDEAD_BEEF);

    // Flush with one buffered response and one in S1.
    RespReady = 1'b0; ReqValid = 1'b1;
    ReqAddress = 32'h0; tick();
    ReqAddress = 32'h4; tick();
    Flush = 1'b1; ReqAddress = 32'h10;
    #0 check("flush_ready", 64'(ReqReady), 64'd0);
    tick();
    Flush = 1'b0; ReqValid = 1'b0;
    check("flush_empty1", 64'(RespValid), 64'd0);
    tick();
    check("flush_empty2", 64'(RespValid), 64'd0);
    base = pop_cnt;
    RespReady = 1'b1; ReqValid = 1'b1; ReqAddress = 32'h8; tick();
    ReqValid = 1'b0;
    drain();
    check("flush_one_resp", 64'(pop_cnt - base), 64'd1);
    check("flush_data", 64'(last_data), 64'h1000_0002);

    // Load colliding with a request.
    LoadEn = 1'b1; LoadAddress = 9'd3; LoadData = 32'hCAFE_0003;
    ReqValid = 1'b1; ReqAddress = 32'hC;
    #0 check("collide_ready", 64'(ReqReady), 64'd0);
    tick();
    LoadEn = 1'b0;
    #0 check("after_load_ready", 64'(ReqReady), 64'd1);
    tick();
    ReqValid = 1'b0;
    drain();
    check("collide_data", 64'(last_data), 64'hCAFE_0003);

    // Reset mid-stream, then re-read.
    ReqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ReqAddress = 32'(4 * i);
      tick();
    end
    Reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ReqReady), 64'd0);
    check("mid_rst_valid", 64'(RespValid), 64'd0);
    check("mid_rst_instr", 64'(RespInstruction), 64'd0);
    tick(); tick();
    Reset = 1'b0; ReqValid = 1'b0;
    tick();
    base = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      ReqValid = 1'b1; ReqAddress = 32'(4 * i);
      tick();
    end
    ReqValid = 1'b0;
    drain();
    check("reread_count", 64'(pop_cnt - base), 64'd8);
    check("reread_last", 64'(last_data), 64'h1000_0007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
